// File: rtl/bist_fail_logger.sv
// Fail logger for the march BIST stage: queues failing (address, read word) pairs in a
// show-ahead FIFO and keeps per-session status (count, first address, overflow, verdict).
module bist_fail_logger #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 4,
    parameter int DEPTH  = 8,
    parameter int CNT_W  = 9,
    parameter int DEDUP  = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              session_start,
    input  logic              bist_done,
    input  logic              fail_in,
    input  logic [ADDR_W-1:0] fail_addr_in,
    input  logic [DATA_W-1:0] fail_data_in,
    output logic              log_valid,
    input  logic              log_ready,
    output logic [ADDR_W-1:0] log_addr,
    output logic [DATA_W-1:0] log_data,
    output logic [CNT_W-1:0]  fail_count,
    output logic [ADDR_W-1:0] first_addr,
    output logic              any_fail,
    output logic              overflow,
    output logic              busy,
    output logic              pass
);
    localparam int PTR_W   = $clog2(DEPTH);
    localparam int ENTRY_W = ADDR_W + DATA_W;

    typedef enum logic [1:0] {IDLE, LOGGING, DONE} state_t;

    state_t state_reg, state_next;

    logic [ENTRY_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]   wr_ptr_reg, rd_ptr_reg, rd_ptr_next;
    logic [PTR_W:0]     occ_reg, occ_next;
    logic               log_valid_reg;
    logic [ADDR_W-1:0]  log_addr_reg;
    logic [DATA_W-1:0]  log_data_reg;
    logic [CNT_W-1:0]   count_reg;
    logic [ADDR_W-1:0]  first_addr_reg;
    logic               any_fail_reg, overflow_reg;
    logic               has_pushed_reg;
    logic [ADDR_W-1:0]  last_addr_reg;

    logic               fail_accept, dup_hit, push_req, push_ok, pop, full;
    logic [ENTRY_W-1:0] head_entry;

    // ---------------- FSM ----------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_reg <= IDLE;
        else      state_reg <= state_next;
    end

    always_comb begin
        state_next = state_reg;
        if (session_start)
            state_next = LOGGING;
        else if (state_reg == LOGGING && bist_done)
            state_next = DONE;
    end

    always_comb begin
        busy = (state_reg == LOGGING);
        pass = (state_reg == DONE) && !any_fail_reg;
    end

    // ---------------- Datapath control ----------------
    always_comb begin
        fail_accept = fail_in && (state_reg == LOGGING) && !session_start;
        // Dedup compares against the last push attempt, which survives pops.
        dup_hit     = (DEDUP != 0) && has_pushed_reg && (fail_addr_in == last_addr_reg);
        push_req    = fail_accept && !dup_hit;
        pop         = log_valid_reg && log_ready && !session_start;
        full        = (occ_reg == (PTR_W+1)'(DEPTH));
        push_ok     = push_req && (!full || pop);
        rd_ptr_next = rd_ptr_reg + PTR_W'(pop);
        occ_next    = occ_reg + (PTR_W+1)'(push_ok) - (PTR_W+1)'(pop);
        // The entry being written this cycle becomes head only when the FIFO drains to it.
        if (push_ok && (wr_ptr_reg == rd_ptr_next))
            head_entry = {fail_addr_in, fail_data_in};
        else
            head_entry = mem[rd_ptr_next];
    end

    always_ff @(posedge clk) begin
        if (push_ok)
            mem[wr_ptr_reg] <= {fail_addr_in, fail_data_in};
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_reg     <= '0;
            rd_ptr_reg     <= '0;
            occ_reg        <= '0;
            log_valid_reg  <= 1'b0;
            log_addr_reg   <= '0;
            log_data_reg   <= '0;
            count_reg      <= '0;
            first_addr_reg <= '0;
            any_fail_reg   <= 1'b0;
            overflow_reg   <= 1'b0;
            has_pushed_reg <= 1'b0;
            last_addr_reg  <= '0;
        end else if (session_start) begin
            wr_ptr_reg     <= '0;
            rd_ptr_reg     <= '0;
            occ_reg        <= '0;
            log_valid_reg  <= 1'b0;
            log_addr_reg   <= '0;
            log_data_reg   <= '0;
            count_reg      <= '0;
            first_addr_reg <= '0;
            any_fail_reg   <= 1'b0;
            overflow_reg   <= 1'b0;
            has_pushed_reg <= 1'b0;
            last_addr_reg  <= '0;
        end else begin
            if (push_ok)
                wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
            rd_ptr_reg    <= rd_ptr_next;
            occ_reg       <= occ_next;
            log_valid_reg <= (occ_next != '0);
            if (occ_next != '0) begin
                log_addr_reg <= head_entry[ENTRY_W-1:DATA_W];
                log_data_reg <= head_entry[DATA_W-1:0];
            end
            if (fail_accept && (count_reg != {CNT_W{1'b1}}))
                count_reg <= count_reg + CNT_W'(1);
            if (fail_accept && !any_fail_reg) begin
                first_addr_reg <= fail_addr_in;
                any_fail_reg   <= 1'b1;
            end
            if (push_req) begin
                has_pushed_reg <= 1'b1;
                last_addr_reg  <= fail_addr_in;
            end
            if (push_req && !push_ok)
                overflow_reg <= 1'b1;
        end
    end

    assign log_valid  = log_valid_reg;
    assign log_addr   = log_addr_reg;
    assign log_data   = log_data_reg;
    assign fail_count = count_reg;
    assign first_addr = first_addr_reg;
    assign any_fail   = any_fail_reg;
    assign overflow   = overflow_reg;
endmodule

// File: tb/tb_bist_fail_logger.sv
// Randomized and directed bench for bist_fail_logger against a queue-based session model.
module tb_bist_fail_logger;
    localparam int ADDR_W = 8, DATA_W = 4, DEPTH = 8, CNT_W = 9, DEDUP = 1;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    logic clk = 1'b0, rst = 1'b0;
    logic session_start = 0, bist_done = 0, fail_in = 0, log_ready = 0;
    logic [ADDR_W-1:0] fail_addr_in = '0;
    logic [DATA_W-1:0] fail_data_in = '0;
    logic log_valid, any_fail, overflow, busy, pass;
    logic [ADDR_W-1:0] log_addr, first_addr;
    logic [DATA_W-1:0] log_data;
    logic [CNT_W-1:0]  fail_count;

    int errors = 0, checks = 0;

    bist_fail_logger #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .DEPTH(DEPTH), .CNT_W(CNT_W),
                       .DEDUP(DEDUP)) dut (
        .clk(clk), .rst(rst), .session_start(session_start), .bist_done(bist_done),
        .fail_in(fail_in), .fail_addr_in(fail_addr_in), .fail_data_in(fail_data_in),
        .log_valid(log_valid), .log_ready(log_ready), .log_addr(log_addr),
        .log_data(log_data), .fail_count(fail_count), .first_addr(first_addr),
        .any_fail(any_fail), .overflow(overflow), .busy(busy), .pass(pass));

    always #5 clk = ~clk;

    // Session model: 0 = idle, 1 = logging, 2 = done
    int m_mode;
    int m_count, m_first, m_last;
    bit m_any, m_ovf, m_has;
    logic [ADDR_W+DATA_W-1:0] m_q[$];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got=0x%0h expected=0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic model_clear();
        m_count = 0; m_first = 0; m_last = 0;
        m_any = 0; m_ovf = 0; m_has = 0;
        m_q.delete();
    endtask

    task automatic model_step(input bit ss, input bit dn, input bit f,
                              input int a, input int d, input bit rdy);
        bit popped;
        if (ss) begin
            model_clear();
            m_mode = 1;
            return;
        end
        popped = rdy && (m_q.size() > 0);
        if (popped) void'(m_q.pop_front());
        if (f && m_mode == 1) begin
            if (m_count < CNT_MAX) m_count++;
            if (!m_any) begin m_any = 1; m_first = a; end
            if (!(DEDUP != 0 && m_has && a == m_last)) begin
                m_has = 1; m_last = a;
                if (m_q.size() < DEPTH) m_q.push_back({a[ADDR_W-1:0], d[DATA_W-1:0]});
                else m_ovf = 1;
            end
        end
        if (dn && m_mode == 1) m_mode = 2;
    endtask

    task automatic compare_all();
        logic [ADDR_W+DATA_W-1:0] head;
        chk("log_valid", 32'(log_valid), 32'(m_q.size() > 0));
        if (m_q.size() > 0) begin
            head = m_q[0];
            chk("log_addr", 32'(log_addr), 32'(head[ADDR_W+DATA_W-1:DATA_W]));
            chk("log_data", 32'(log_data), 32'(head[DATA_W-1:0]));
        end
        chk("fail_count", 32'(fail_count), 32'(m_count));
        chk("first_addr", 32'(first_addr), 32'(m_first));
        chk("any_fail", 32'(any_fail), 32'(m_any));
        chk("overflow", 32'(overflow), 32'(m_ovf));
        chk("busy", 32'(busy), 32'(m_mode == 1));
        chk("pass", 32'(pass), 32'(m_mode == 2 && !m_any));
    endtask

    // One clock cycle: inputs driven after a falling edge, outputs checked at the next one.
    task automatic cyc(input bit ss, input bit dn, input bit f,
                       input int a, input int d, input bit rdy);
        session_start = ss; bist_done = dn; fail_in = f;
        fail_addr_in = a[ADDR_W-1:0]; fail_data_in = d[DATA_W-1:0]; log_ready = rdy;
        @(posedge clk);
        model_step(ss, dn, f, a, d, rdy);
        @(negedge clk);
        session_start = 0; bist_done = 0; fail_in = 0; log_ready = 0;
        compare_all();
    endtask

    task automatic drain(output int n, output int addrs[$]);
        n = 0;
        addrs.delete();
        for (int i = 0; i < 4 * DEPTH && log_valid; i++) begin
            addrs.push_back(int'(log_addr));
            $display("pop addr=0x%02h data=0x%0h", log_addr, log_data);
            cyc(0, 0, 0, 0, 0, 1);
            n++;
        end
        chk("drain_timeout", 32'(log_valid), 32'(0));
    endtask

    initial begin
        int n;
        int addrs[$];
        m_mode = 0;
        model_clear();

        // Reset state
        repeat (2) @(negedge clk);
        compare_all();
        rst = 1'b1;
        @(negedge clk);
        compare_all();

        // T1: async reset mid-session with 3 queued entries
        cyc(1, 0, 0, 0, 0, 0);
        cyc(0, 0, 1, 8'h21, 1, 0);
        cyc(0, 0, 1, 8'h22, 2, 0);
        cyc(0, 0, 1, 8'h23, 3, 0);
        #2 rst = 1'b0;
        #1;
        m_mode = 0; model_clear();
        chk("t1_rst_valid", 32'(log_valid), 0);
        chk("t1_rst_count", 32'(fail_count), 0);
        chk("t1_rst_busy", 32'(busy), 0);
        chk("t1_rst_addr", 32'(log_addr), 0);
        @(negedge clk);
        rst = 1'b1;
        cyc(0, 0, 1, 8'h44, 4, 0);
        chk("t1_ignored", 32'(fail_count), 0);
        $display("T1 reset mid-session done");

        // T2: dedup of repeated address, done, drain
        cyc(1, 0, 0, 0, 0, 0);
        cyc(0, 0, 1, 8'h05, 4'h1, 0);
        cyc(0, 0, 1, 8'h05, 4'h2, 0);
        cyc(0, 0, 1, 8'h1A, 4'h3, 0);
        cyc(0, 1, 0, 0, 0, 0);
        chk("t2_count", 32'(fail_count), 3);
        chk("t2_first", 32'(first_addr), 32'h05);
        drain(n, addrs);
        chk("t2_npops", 32'(n), 2);
        if (n == 2) begin
            chk("t2_pop0", 32'(addrs[0]), 32'h05);
            chk("t2_pop1", 32'(addrs[1]), 32'h1A);
        end
        chk("t2_pass", 32'(pass), 0);
        $display("T2 dedup session done");

        // T3: overflow, then push+pop on full
        cyc(1, 0, 0, 0, 0, 0);
        for (int i = 0; i < 10; i++) cyc(0, 0, 1, 8'h10 + i, i, 0);
        chk("t3_ovf", 32'(overflow), 1);
        chk("t3_count", 32'(fail_count), 10);
        cyc(0, 0, 1, 8'h40, 4'hF, 1);
        drain(n, addrs);
        chk("t3_npops", 32'(n), DEPTH);
        if (n == DEPTH) begin
            chk("t3_pop_first", 32'(addrs[0]), 32'h11);
            chk("t3_pop_last", 32'(addrs[DEPTH-1]), 32'h40);
        end
        $display("T3 overflow session done");

        // T4: clean session passes; fails after done are ignored
        cyc(1, 0, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0, 0);
        cyc(0, 1, 0, 0, 0, 0);
        chk("t4_pass", 32'(pass), 1);
        chk("t4_any", 32'(any_fail), 0);
        cyc(0, 0, 1, 8'h77, 7, 0);
        chk("t4_count_after_done", 32'(fail_count), 0);
        chk("t4_valid", 32'(log_valid), 0);
        $display("T4 clean session done");

        // T5: counter saturation
        cyc(1, 0, 0, 0, 0, 0);
        for (int i = 0; i < 520; i++) cyc(0, 0, 1, i & 8'hFF, i, 0);
        chk("t5_sat", 32'(fail_count), CNT_MAX);
        $display("T5 saturation done");

        // T6: session_start beats a coincident fail
        cyc(1, 0, 1, 8'h33, 5, 0);
        chk("t6_count", 32'(fail_count), 0);
        chk("t6_valid", 32'(log_valid), 0);
        $display("T6 start-vs-fail done");

        // Randomized traffic
        for (int i = 0; i < 1500; i++) begin
            cyc(($urandom_range(0, 59) == 0), ($urandom_range(0, 39) == 0),
                $urandom_range(0, 1) == 1, int'($urandom_range(0, 7)),
                int'($urandom_range(0, 15)), ($urandom_range(0, 2) == 0));
        end
        $display("random phase done");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
